// File: rtl/key_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser, debounce FSM,
// clean level, one-cycle press/release pulses and an auto-repeat pulse train.
module key_conditioner #(
    parameter int N_SW         = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_press,
    output logic [N_SW-1:0] sw_release,
    output logic [N_SW-1:0] sw_rpt
);

    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int DEB_W   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEB_P  = 3'd1,
        HELD   = 3'd2,
        REPEAT = 3'd3,
        DEB_R  = 3'd4
    } state_t;

    logic [N_SW-1:0] sync1_q;
    logic [N_SW-1:0] sync2_q;
    logic [N_SW-1:0] s_pressed;

    // Synchronisers park at the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= {N_SW{ACTIVE_LOW}};
            sync2_q <= {N_SW{ACTIVE_LOW}};
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s_pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_chan
            state_t             state_q, state_d;
            state_t             ret_q, ret_d;
            logic [DEB_W-1:0]   deb_q, deb_d;
            logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
            logic               press_q, press_d;
            logic               release_q, release_d;
            logic               rpt_q, rpt_d;
            logic               s;

            assign s = s_pressed[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q   <= IDLE;
                    ret_q     <= HELD;
                    deb_q     <= '0;
                    rpt_cnt_q <= '0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    rpt_q     <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    ret_q     <= ret_d;
                    deb_q     <= deb_d;
                    rpt_cnt_q <= rpt_cnt_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                    rpt_q     <= rpt_d;
                end
            end

            always_comb begin
                state_d   = state_q;
                ret_d     = ret_q;
                deb_d     = deb_q;
                rpt_cnt_d = rpt_cnt_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                rpt_d     = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (s) begin
                            state_d = DEB_P;
                            deb_d   = DEB_ONE;
                        end
                    end
                    DEB_P: begin
                        if (!s) begin
                            state_d = IDLE;
                            deb_d   = '0;
                        end else if (deb_q == DEB_LAST) begin
                            state_d   = HELD;
                            deb_d     = '0;
                            rpt_cnt_d = '0;
                            press_d   = 1'b1;
                            rpt_d     = 1'b1;
                        end else begin
                            deb_d = deb_q + DEB_ONE;
                        end
                    end
                    HELD, REPEAT: begin
                        if (!s) begin
                            // rpt_cnt is left untouched so a bounce resumes the train in phase
                            state_d = DEB_R;
                            ret_d   = state_q;
                            deb_d   = DEB_ONE;
                        end else if (rpt_cnt_q == ((state_q == HELD) ? DLY_LAST : PER_LAST)) begin
                            state_d   = REPEAT;
                            rpt_cnt_d = '0;
                            rpt_d     = 1'b1;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_ONE;
                        end
                    end
                    DEB_R: begin
                        if (s) begin
                            state_d = ret_q;
                            deb_d   = '0;
                        end else if (deb_q == DEB_LAST) begin
                            state_d   = IDLE;
                            deb_d     = '0;
                            rpt_cnt_d = '0;
                            release_d = 1'b1;
                        end else begin
                            deb_d = deb_q + DEB_ONE;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        deb_d     = '0;
                        rpt_cnt_d = '0;
                    end
                endcase
            end

            assign sw_level[gi]   = (state_q == HELD) || (state_q == REPEAT) || (state_q == DEB_R);
            assign sw_press[gi]   = press_q;
            assign sw_release[gi] = release_q;
            assign sw_rpt[gi]     = rpt_q;
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing;
// expected pulse cycles are hand-computed from the raw edge times.
module tb_key_conditioner;

    localparam int N = 4;
    localparam int LOGN = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_level, sw_press, sw_release, sw_rpt;

    key_conditioner #(
        .N_SW(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(8), .REPEAT_DLY(40), .REPEAT_PER(10)
    ) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw),
        .sw_level(sw_level), .sw_press(sw_press), .sw_release(sw_release), .sw_rpt(sw_rpt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Pulse log, sampled on the falling edge
    int press_cyc [N][LOGN];
    int rel_cyc   [N][LOGN];
    int rpt_cyc   [N][LOGN];
    int press_n   [N];
    int rel_n     [N];
    int rpt_n     [N];
    int lvl_hi    [N];
    int viol = 0;
    logic [N-1:0] prev_press = '0, prev_rel = '0, prev_rpt = '0;

    initial begin
        for (int c = 0; c < N; c++) begin
            press_n[c] = 0; rel_n[c] = 0; rpt_n[c] = 0; lvl_hi[c] = 0;
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (sw_press[c]) begin
                if (press_n[c] < LOGN) press_cyc[c][press_n[c]] = cyc;
                press_n[c]++;
            end
            if (sw_release[c]) begin
                if (rel_n[c] < LOGN) rel_cyc[c][rel_n[c]] = cyc;
                rel_n[c]++;
            end
            if (sw_rpt[c]) begin
                if (rpt_n[c] < LOGN) rpt_cyc[c][rpt_n[c]] = cyc;
                rpt_n[c]++;
            end
            if (sw_level[c]) lvl_hi[c]++;
            if (sw_press[c] && sw_release[c]) viol++;
            if (sw_rpt[c] && !sw_level[c]) viol++;
            if ((sw_press[c] && prev_press[c]) || (sw_release[c] && prev_rel[c]) ||
                (sw_rpt[c] && prev_rpt[c])) viol++;
        end
        prev_press = sw_press;
        prev_rel   = sw_release;
        prev_rpt   = sw_rpt;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic int get_rpt(input int c, input int i);
        return (i < LOGN) ? rpt_cyc[c][i] : -1;
    endfunction

    function automatic int get_press(input int c, input int i);
        return (i < LOGN) ? press_cyc[c][i] : -1;
    endfunction

    function automatic int get_rel(input int c, input int i);
        return (i < LOGN) ? rel_cyc[c][i] : -1;
    endfunction

    initial begin
        int c0, t, r;
        int bp, br, bt, bl;
        int bp4 [N];
        int bt4 [N];
        int ex [8];

        rst    = 1'b1;
        sw_raw = 4'hF;
        step(3);
        $display("reset: level=%b press=%b release=%b rpt=%b", sw_level, sw_press, sw_release, sw_rpt);
        chk("rst_level",   32'(sw_level),   0);
        chk("rst_press",   32'(sw_press),   0);
        chk("rst_release", 32'(sw_release), 0);
        chk("rst_rpt",     32'(sw_rpt),     0);
        rst = 1'b0;
        step(2);

        // 1: clean press on channel 0, then a steady release
        c0 = cyc; bt = rpt_n[0];
        sw_raw[0] = 1'b0;
        step(9);
        chk("t1_pre_level", 32'(sw_level), 0);
        chk("t1_pre_press", 32'(sw_press), 0);
        step(1);
        $display("t1 press: cycle %0d level=%b press=%b rpt=%b", cyc - c0, sw_level, sw_press, sw_rpt);
        chk("t1_press", 32'(sw_press), 1);
        chk("t1_rpt",   32'(sw_rpt),   1);
        chk("t1_level", 32'(sw_level), 1);
        step(1);
        chk("t1_press_width", 32'(sw_press), 0);
        chk("t1_level_hold",  32'(sw_level), 1);
        sw_raw[0] = 1'b1;
        step(9);
        chk("t1_pre_release", 32'(sw_release), 0);
        chk("t1_level_in_debr", 32'(sw_level), 1);
        step(1);
        $display("t1 release: level=%b release=%b", sw_level, sw_release);
        chk("t1_release",       32'(sw_release), 1);
        chk("t1_level_cleared", 32'(sw_level),   0);
        step(1);
        chk("t1_release_width", 32'(sw_release), 0);
        chk("t1_rpt_count",     rpt_n[0] - bt,   1);

        // 2: bouncing channel 1 never accepted
        bp = press_n[1]; br = rel_n[1]; bt = rpt_n[1]; bl = lvl_hi[1];
        for (int i = 0; i < 10; i++) begin
            sw_raw[1] = (i % 2 == 1);
            step(3);
        end
        step(15);
        $display("t2 bounce: presses=%0d releases=%0d rpts=%0d level_cycles=%0d",
                 press_n[1] - bp, rel_n[1] - br, rpt_n[1] - bt, lvl_hi[1] - bl);
        chk("t2_no_press",   press_n[1] - bp, 0);
        chk("t2_no_release", rel_n[1] - br,   0);
        chk("t2_no_rpt",     rpt_n[1] - bt,   0);
        chk("t2_no_level",   lvl_hi[1] - bl,  0);

        // 3: auto-repeat on channel 2
        c0 = cyc; bp = press_n[2]; br = rel_n[2]; bt = rpt_n[2];
        sw_raw[2] = 1'b0;
        t = c0 + 10;
        wait_until(t + 101);
        ex[0] = 0;
        for (int k = 1; k < 8; k++) ex[k] = 30 + 10 * k;
        $display("t3 repeat: presses=%0d rpts=%0d", press_n[2] - bp, rpt_n[2] - bt);
        chk("t3_press_count", press_n[2] - bp, 1);
        chk("t3_press_cycle", get_press(2, bp), t);
        chk("t3_rpt_count",   rpt_n[2] - bt, 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t3_rpt%0d", k), get_rpt(2, bt + k), t + ex[k]);
        r = cyc;
        sw_raw[2] = 1'b1;
        wait_until(r + 12);
        chk("t3_release_count", rel_n[2] - br, 1);
        chk("t3_release_cycle", get_rel(2, br), r + 10);
        chk("t3_rpt_after_release", rpt_n[2] - bt, 8);

        // 4: glitch during REPEAT on channel 0 freezes the repeat phase
        c0 = cyc; br = rel_n[0]; bt = rpt_n[0];
        sw_raw[0] = 1'b0;
        t = c0 + 10;
        wait_until(t + 52);
        sw_raw[0] = 1'b1;
        wait_until(t + 56);
        sw_raw[0] = 1'b0;
        wait_until(t + 62);
        chk("t4_glitch_no_release", rel_n[0] - br, 0);
        chk("t4_glitch_level", 32'(sw_level[0]), 1);
        wait_until(t + 77);
        r = cyc;
        sw_raw[0] = 1'b1;
        wait_until(r + 12);
        ex[0] = 0; ex[1] = 40; ex[2] = 50; ex[3] = 65; ex[4] = 75;
        $display("t4 glitch: rpts=%0d releases=%0d", rpt_n[0] - bt, rel_n[0] - br);
        chk("t4_rpt_count", rpt_n[0] - bt, 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t4_rpt%0d", k), get_rpt(0, bt + k), t + ex[k]);
        chk("t4_release_count", rel_n[0] - br, 1);
        chk("t4_release_cycle", get_rel(0, br), r + 10);

        // 5: reset while channel 3 is held
        c0 = cyc; bp = press_n[3]; bt = rpt_n[3];
        sw_raw[3] = 1'b0;
        wait_until(c0 + 30);
        chk("t5_level_before", 32'(sw_level), 8);
        rst = 1'b1;
        step(1);
        $display("t5 reset: level=%b press=%b release=%b rpt=%b", sw_level, sw_press, sw_release, sw_rpt);
        chk("t5_rst_level",   32'(sw_level),   0);
        chk("t5_rst_release", 32'(sw_release), 0);
        rst = 1'b0;
        r = cyc;
        wait_until(r + 12);
        chk("t5_press_count",  press_n[3] - bp, 2);
        chk("t5_repress_cycle", get_press(3, bp + 1), r + 10);
        chk("t5_rpt_count",    rpt_n[3] - bt, 2);
        chk("t5_rerpt_cycle",  get_rpt(3, bt + 1), r + 10);
        sw_raw[3] = 1'b1;
        step(15);

        // 6: all channels pressed together
        c0 = cyc;
        for (int c = 0; c < N; c++) begin
            bp4[c] = press_n[c]; bt4[c] = rpt_n[c];
        end
        sw_raw = 4'h0;
        t = c0 + 10;
        wait_until(t);
        $display("t6 press: press=%b rpt=%b", sw_press, sw_rpt);
        chk("t6_press_all", 32'(sw_press), 15);
        wait_until(t + 40);
        chk("t6_rpt_aligned", 32'(sw_rpt), 15);
        wait_until(t + 71);
        ex[0] = 0; ex[1] = 40; ex[2] = 50; ex[3] = 60; ex[4] = 70;
        for (int c = 0; c < N; c++) begin
            chk($sformatf("t6_press_count%0d", c), press_n[c] - bp4[c], 1);
            chk($sformatf("t6_rpt_count%0d", c), rpt_n[c] - bt4[c], 5);
            for (int k = 0; k < 5; k++)
                chk($sformatf("t6_ch%0d_rpt%0d", c, k), get_rpt(c, bt4[c] + k), t + ex[k]);
        end
        r = cyc;
        sw_raw = 4'hF;
        wait_until(r + 10);
        $display("t6 release: release=%b level=%b", sw_release, sw_level);
        chk("t6_release_all", 32'(sw_release), 15);
        chk("t6_level_all_clear", 32'(sw_level), 0);
        step(2);

        chk("pulse_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
